id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter NOP_ALUOP, default 3'b000, ALUOp driven on ex_alu_op while the stage holds no valid instruction.
REQ-002 Parameter CNT_W, default 16, width of the load-use stall counter.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Port clk  in  1  rising-edge clock.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports id_valid in 1 / id_ready out 1: upstream handshake; transfer occurs when both are 1 on a clk edge.
REQ-007 Ports id_alu_op in 3, id_rs1_data in 32, id_rs2_data in 32, id_imm in 32: decoded operation, register-file operands and immediate.
REQ-008 Ports id_rs1, id_rs2, id_rd in 5: source and destination register indices.
REQ-009 Ports id_alu_src, id_reg_write, id_mem_read in 1: B=immediate select, writeback enable, load flag.
REQ-010 Ports ex_valid out 1 / ex_ready in 1: downstream handshake toward the ALU/EX stage.
REQ-011 Ports ex_alu_op out 3, ex_a out 32, ex_b out 32, ex_store_data out 32, ex_rd out 5, ex_reg_write out 1, ex_mem_read out 1: registered payload.
REQ-012 Ports fwd1_we in 1, fwd1_rd in 5, fwd1_data in 32: EX/MEM forwarding source.
REQ-013 Ports fwd2_we in 1, fwd2_rd in 5, fwd2_data in 32: MEM/WB forwarding source.
REQ-014 Port flush in 1: discard held and incoming instruction.
REQ-015 Ports load_use_stall out 1 (combinational), cnt_clr in 1, stall_cnt out CNT_W.

Function
REQ-016 Hazard: load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (ex_rd==id_rs2 & !id_alu_src)) & id_valid.
REQ-017 id_ready = (!ex_valid | ex_ready) & !load_use_stall; combinational, no dependence on id_valid except through REQ-016.
REQ-018 Forwarding per source index r: r==0 -> register data; else fwd1 match (we & rd==r) wins; else fwd2 match; else register data.
REQ-019 Captured ex_a = forwarded rs1; ex_b = id_alu_src ? id_imm : forwarded rs2; ex_store_data = forwarded rs2 always.
REQ-020 Capture: on id_valid & id_ready & !flush, all payload registers load and ex_valid<=1; latency one cycle.
REQ-021 Drain without refill: ex_valid & ex_ready & !(id_valid & id_ready) -> ex_valid<=0.
REQ-022 Bubble: when load_use_stall & (!ex_valid | ex_ready), ex_valid<=0, ex_alu_op<=NOP_ALUOP, ex_reg_write<=0, ex_mem_read<=0.
REQ-023 Hold: ex_valid & !ex_ready -> all payload and ex_valid unchanged; operands are not re-forwarded while held.
REQ-024 Flush priority highest: flush=1 -> ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0, ex_alu_op<=NOP_ALUOP, incoming transfer discarded (still counts as accepted upstream).
REQ-025 Whenever ex_valid is 0, ex_reg_write and ex_mem_read shall be 0.
REQ-026 stall_cnt increments by 1 each cycle load_use_stall=1, saturates at all-ones; cnt_clr=1 sets it to 0 and wins over increment.

Reset
REQ-027 rst_n=0 asynchronously sets ex_valid=0, ex_alu_op=NOP_ALUOP, ex_a/ex_b/ex_store_data=0, ex_rd=0, ex_reg_write=0, ex_mem_read=0, stall_cnt=0.
REQ-028 Reset asserted mid-hold discards the held instruction; first capture possible on the first rising edge after deassertion.

Verification
REQ-029 Capture: id_valid=1, alu_op=3'b001, rs1_data=10, rs2_data=3, alu_src=0, ex_ready=1 -> next cycle ex_valid=1, ex_a=10, ex_b=3, ex_alu_op=3'b001.
REQ-030 Forward priority: id_rs1=5, fwd1(we,rd=5,data=0x11), fwd2(we,rd=5,data=0x22) -> ex_a=0x11; id_rs1=0 with both matching rd=0 -> ex_a=rs1_data.
REQ-031 Load-use: held load ex_rd=7, ex_mem_read=1, ex_ready=1; next id_rs2=7, alu_src=0 -> id_ready=0, one bubble (ex_valid=0, ex_alu_op=NOP_ALUOP), stall_cnt=1.
REQ-032 Backpressure: ex_valid=1, ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0, payload unchanged; ex_ready=1 -> new instruction captured next edge.
REQ-033 Flush: flush=1 with id_valid=1, id_ready=1 -> next cycle ex_valid=0, ex_reg_write=0; stall_cnt saturation at 0xFFFF holds, cnt_clr -> 0.
REQ-034 Reset mid-hold: ex_valid=1, ex_ready=0, rst_n pulsed low -> all outputs at REQ-027 values immediately, without a clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard detection and a stall counter.
// Latency: one cycle from an accepted id_valid/id_ready transfer to ex_valid.
// Backpressure: ex_ready low holds the payload and drops id_ready; a load-use hazard also drops id_ready.
module id_ex_stage #(
    parameter logic [2:0] NOP_ALUOP = 3'b000,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // decode side
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [2:0]       id_alu_op,
    input  logic [31:0]      id_rs1_data,
    input  logic [31:0]      id_rs2_data,
    input  logic [31:0]      id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    // execute side
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [2:0]       ex_alu_op,
    output logic [31:0]      ex_a,
    output logic [31:0]      ex_b,
    output logic [31:0]      ex_store_data,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    // forwarding sources
    input  logic             fwd1_we,
    input  logic [4:0]       fwd1_rd,
    input  logic [31:0]      fwd1_data,
    input  logic             fwd2_we,
    input  logic [4:0]       fwd2_rd,
    input  logic [31:0]      fwd2_data,
    // control and status
    input  logic             flush,
    output logic             load_use_stall,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [2:0]  alu_op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
    } ex_pay_t;

    localparam ex_pay_t EX_RST = '{
        alu_op:     NOP_ALUOP,
        a:          32'd0,
        b:          32'd0,
        store_data: 32'd0,
        rd:         5'd0,
        reg_write:  1'b0,
        mem_read:   1'b0
    };

    ex_pay_t          ex_q;
    ex_pay_t          ex_d;
    ex_pay_t          cap_pay;
    logic             ex_vld_q;
    logic             ex_vld_d;
    logic             id_fire;
    logic             retire;
    logic             rs1_hit;
    logic             rs2_hit;
    logic [31:0]      rs1_fwd_dat;
    logic [31:0]      rs2_fwd_dat;
    logic [CNT_W-1:0] stall_cnt_q;

    // Nearer stage (EX/MEM) wins; x0 never forwards.
    function automatic logic [31:0] fwd_pick(
        input logic [4:0]  r,
        input logic [31:0] reg_dat,
        input logic        we1,
        input logic [4:0]  rd1,
        input logic [31:0] dat1,
        input logic        we2,
        input logic [4:0]  rd2,
        input logic [31:0] dat2
    );
        logic [31:0] res;
        res = reg_dat;
        if (r != 5'd0) begin
            if (we1 && (rd1 == r)) begin
                res = dat1;
            end else if (we2 && (rd2 == r)) begin
                res = dat2;
            end
        end
        return res;
    endfunction

    assign rs1_fwd_dat = fwd_pick(id_rs1, id_rs1_data, fwd1_we, fwd1_rd, fwd1_data,
                                  fwd2_we, fwd2_rd, fwd2_data);
    assign rs2_fwd_dat = fwd_pick(id_rs2, id_rs2_data, fwd1_we, fwd1_rd, fwd1_data,
                                  fwd2_we, fwd2_rd, fwd2_data);

    // rs2 only matters to the hazard when it feeds the ALU, not the immediate.
    assign rs1_hit        = (ex_q.rd == id_rs1);
    assign rs2_hit        = (ex_q.rd == id_rs2) && !id_alu_src;
    assign load_use_stall = ex_vld_q && ex_q.mem_read && (ex_q.rd != 5'd0)
                            && (rs1_hit || rs2_hit) && id_valid;

    assign id_ready = (!ex_vld_q || ex_ready) && !load_use_stall;
    assign id_fire  = id_valid && id_ready;

    always_comb begin
        cap_pay            = EX_RST;
        cap_pay.alu_op     = id_alu_op;
        cap_pay.a          = rs1_fwd_dat;
        cap_pay.b          = id_alu_src ? id_imm : rs2_fwd_dat;
        cap_pay.store_data = rs2_fwd_dat;
        cap_pay.rd         = id_rd;
        cap_pay.reg_write  = id_reg_write;
        cap_pay.mem_read   = id_mem_read;
    end

    // A load-use bubble is just a drain with no refill, since id_ready is low then.
    assign retire = flush || (!id_fire && ex_vld_q && ex_ready);

    always_comb begin
        ex_vld_d = ex_vld_q;
        ex_d     = ex_q;
        if (retire) begin
            ex_vld_d       = 1'b0;
            ex_d.alu_op    = NOP_ALUOP;
            ex_d.reg_write = 1'b0;
            ex_d.mem_read  = 1'b0;
        end else if (id_fire) begin
            ex_vld_d = 1'b1;
            ex_d     = cap_pay;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld_q <= 1'b0;
            ex_q     <= EX_RST;
        end else begin
            ex_vld_q <= ex_vld_d;
            ex_q     <= ex_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (cnt_clr) begin
            stall_cnt_q <= '0;
        end else if (load_use_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign ex_valid      = ex_vld_q;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_a          = ex_q.a;
    assign ex_b          = ex_q.b;
    assign ex_store_data = ex_q.store_data;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by a random phase, all against a cycle model.
module tb_id_ex_stage;

    localparam logic [2:0] NOP = 3'b000;
    localparam int         CW  = 16;
    localparam int         CNT_MAX = 65535;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic          id_ready;
    logic [2:0]    id_alu_op;
    logic [31:0]   id_rs1_data;
    logic [31:0]   id_rs2_data;
    logic [31:0]   id_imm;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic [4:0]    id_rd;
    logic          id_alu_src;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          ex_valid;
    logic          ex_ready;
    logic [2:0]    ex_alu_op;
    logic [31:0]   ex_a;
    logic [31:0]   ex_b;
    logic [31:0]   ex_store_data;
    logic [4:0]    ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          fwd1_we;
    logic [4:0]    fwd1_rd;
    logic [31:0]   fwd1_data;
    logic          fwd2_we;
    logic [4:0]    fwd2_rd;
    logic [31:0]   fwd2_data;
    logic          flush;
    logic          load_use_stall;
    logic          cnt_clr;
    logic [CW-1:0] stall_cnt;

    id_ex_stage #(.NOP_ALUOP(NOP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready), .id_alu_op(id_alu_op),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_op(ex_alu_op),
        .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .fwd1_we(fwd1_we), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
        .fwd2_we(fwd2_we), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
        .flush(flush), .load_use_stall(load_use_stall),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Reference state: what the EX register should hold.
    bit          m_valid;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b, m_sd;
    logic [4:0]  m_rd;
    bit          m_rw, m_mr;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] d);
        if (r == 5'd0) return d;
        if (fwd1_we && fwd1_rd == r) return fwd1_data;
        if (fwd2_we && fwd2_rd == r) return fwd2_data;
        return d;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = NOP; m_a = 0; m_b = 0; m_sd = 0;
        m_rd = 0; m_rw = 0; m_mr = 0; m_cnt = 0;
    endtask

    task automatic check_regs(input string pfx);
        chk({pfx, ".ex_valid"},      ex_valid,      m_valid);
        chk({pfx, ".ex_alu_op"},     ex_alu_op,     m_op);
        chk({pfx, ".ex_a"},          ex_a,          m_a);
        chk({pfx, ".ex_b"},          ex_b,          m_b);
        chk({pfx, ".ex_store_data"}, ex_store_data, m_sd);
        chk({pfx, ".ex_rd"},         ex_rd,         m_rd);
        chk({pfx, ".ex_reg_write"},  ex_reg_write,  m_rw);
        chk({pfx, ".ex_mem_read"},   ex_mem_read,   m_mr);
        chk({pfx, ".stall_cnt"},     stall_cnt,     m_cnt);
    endtask

    // One clock: check handshake outputs, advance the model, check registers after the edge.
    task automatic tick(input string pfx, input bit do_chk);
        bit stall, rdy, fire;
        #1;
        stall = m_valid && m_mr && (m_rd != 0)
                && (m_rd == id_rs1 || (m_rd == id_rs2 && !id_alu_src)) && id_valid;
        rdy   = (!m_valid || ex_ready) && !stall;
        fire  = id_valid && rdy;
        if (do_chk) begin
            chk({pfx, ".id_ready"},       id_ready,       rdy);
            chk({pfx, ".load_use_stall"}, load_use_stall, stall);
        end
        @(posedge clk);
        if (cnt_clr) m_cnt = 0;
        else if (stall && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        if (flush || (!fire && m_valid && ex_ready)) begin
            m_valid = 0; m_op = NOP; m_rw = 0; m_mr = 0;
        end else if (fire) begin
            m_valid = 1; m_op = id_alu_op;
            m_a  = mfwd(id_rs1, id_rs1_data);
            m_sd = mfwd(id_rs2, id_rs2_data);
            m_b  = id_alu_src ? id_imm : m_sd;
            m_rd = id_rd; m_rw = id_reg_write; m_mr = id_mem_read;
        end
        #1;
        if (do_chk) check_regs(pfx);
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                             input logic src, input logic rw, input logic mr);
        id_valid = 1; id_alu_op = op; id_rs1 = rs1; id_rs1_data = d1;
        id_rs2 = rs2; id_rs2_data = d2; id_rd = rd; id_alu_src = src;
        id_reg_write = rw; id_mem_read = mr;
    endtask

    initial begin
        rst_n = 0; id_valid = 0; id_alu_op = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_imm = 32'h0000_0777; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_src = 0;
        id_reg_write = 0; id_mem_read = 0; ex_ready = 1;
        fwd1_we = 0; fwd1_rd = 0; fwd1_data = 0; fwd2_we = 0; fwd2_rd = 0; fwd2_data = 0;
        flush = 0; cnt_clr = 0;
        model_reset();

        #12;
        check_regs("reset");
        rst_n = 1;

        // Basic capture with register operands
        set_instr(3'b001, 5'd1, 32'd10, 5'd2, 32'd3, 5'd3, 1'b0, 1'b1, 1'b0);
        tick("cap", 1);
        chk("cap.valid_const", ex_valid, 1);
        chk("cap.a_const", ex_a, 32'd10);
        chk("cap.b_const", ex_b, 32'd3);
        chk("cap.op_const", ex_alu_op, 3'b001);

        // Forward priority and x0
        set_instr(3'b010, 5'd5, 32'h99, 5'd2, 32'd4, 5'd4, 1'b0, 1'b1, 1'b0);
        fwd1_we = 1; fwd1_rd = 5; fwd1_data = 32'h11;
        fwd2_we = 1; fwd2_rd = 5; fwd2_data = 32'h22;
        tick("fwd1", 1);
        chk("fwd1.a_const", ex_a, 32'h11);
        fwd1_we = 0;
        tick("fwd2", 1);
        chk("fwd2.a_const", ex_a, 32'h22);
        fwd1_we = 1; fwd1_rd = 0; fwd2_rd = 0; id_rs1 = 0; id_rs1_data = 32'h55;
        tick("fwd0", 1);
        chk("fwd0.a_const", ex_a, 32'h55);
        // Immediate selects B while store data still forwards rs2
        id_rs2 = 5'd6; fwd2_rd = 5'd6; id_alu_src = 1;
        tick("imm", 1);
        chk("imm.b_const", ex_b, 32'h777);
        chk("imm.sd_const", ex_store_data, 32'h22);
        fwd1_we = 0; fwd2_we = 0;

        // Load-use hazard: load to x7 then consumer on rs2
        set_instr(3'b011, 5'd1, 32'd1, 5'd2, 32'd2, 5'd7, 1'b0, 1'b1, 1'b1);
        tick("ld", 1);
        set_instr(3'b100, 5'd1, 32'd1, 5'd7, 32'd70, 5'd8, 1'b0, 1'b1, 1'b0);
        #1;
        chk("lu.id_ready_const", id_ready, 0);
        chk("lu.stall_const", load_use_stall, 1);
        tick("lu", 1);
        chk("lu.bubble_valid", ex_valid, 0);
        chk("lu.bubble_op", ex_alu_op, NOP);
        chk("lu.cnt_const", stall_cnt, 1);
        tick("lu_go", 1);
        chk("lu_go.rd_const", ex_rd, 5'd8);

        // Backpressure for three cycles, operands change but must not be re-forwarded
        ex_ready = 0;
        set_instr(3'b010, 5'd9, 32'h1234, 5'd2, 32'd5, 5'd9, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            fwd1_we = 1; fwd1_rd = 5'd9; fwd1_data = 32'hA0 + i;
            tick("bp", 1);
            chk("bp.rd_const", ex_rd, 5'd8);
        end
        ex_ready = 1;
        tick("bp_rel", 1);
        chk("bp_rel.rd_const", ex_rd, 5'd9);
        fwd1_we = 0;

        // Flush kills both held and incoming instruction
        flush = 1;
        set_instr(3'b101, 5'd1, 32'd1, 5'd2, 32'd2, 5'd10, 1'b0, 1'b1, 1'b1);
        tick("flush", 1);
        chk("flush.valid_const", ex_valid, 0);
        chk("flush.rw_const", ex_reg_write, 0);
        flush = 0;

        // Saturate the stall counter with a held load and a permanent consumer
        set_instr(3'b011, 5'd1, 32'd1, 5'd2, 32'd2, 5'd7, 1'b0, 1'b1, 1'b1);
        tick("sat_ld", 1);
        ex_ready = 0;
        set_instr(3'b001, 5'd7, 32'd1, 5'd2, 32'd2, 5'd3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < CNT_MAX + 4; i++) tick("sat", 0);
        check_regs("sat");
        chk("sat.cnt_const", stall_cnt, 32'hFFFF);
        cnt_clr = 1;
        tick("clr", 1);
        chk("clr.cnt_const", stall_cnt, 0);
        cnt_clr = 0;

        // Asynchronous reset while holding
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_regs("arst");
        chk("arst.valid_const", ex_valid, 0);
        rst_n = 1;
        ex_ready = 1;
        set_instr(3'b110, 5'd3, 32'hBEEF, 5'd4, 32'd1, 5'd11, 1'b0, 1'b1, 1'b0);
        tick("post_rst", 1);
        chk("post_rst.a_const", ex_a, 32'hBEEF);

        // Random traffic over a small register range to provoke hazards and forwarding
        for (int i = 0; i < 400; i++) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_alu_op    = 3'($urandom_range(0, 7));
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_rd        = 5'($urandom_range(0, 3));
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_imm       = $urandom;
            id_alu_src   = 1'($urandom_range(0, 1));
            id_reg_write = 1'($urandom_range(0, 1));
            id_mem_read  = 1'($urandom_range(0, 1));
            ex_ready     = ($urandom_range(0, 3) != 0);
            fwd1_we      = 1'($urandom_range(0, 1));
            fwd1_rd      = 5'($urandom_range(0, 3));
            fwd1_data    = $urandom;
            fwd2_we      = 1'($urandom_range(0, 1));
            fwd2_rd      = 5'($urandom_range(0, 3));
            fwd2_data    = $urandom;
            flush        = ($urandom_range(0, 19) == 0);
            cnt_clr      = ($urandom_range(0, 19) == 0);
            tick("rnd", 1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
